// File: rtl/text_pkg.sv
// Shared types and constants for the character-cell text overlay.
package text_pkg;

  typedef logic [7:0] char_t;

  localparam int    CHAR_W     = 8;
  localparam int    CHAR_H     = 8;
  localparam char_t CHAR_SPACE = 8'h20;
  localparam int    RENDER_LAT = 3;

  typedef enum logic {
    CLEAR,
    IDLE
  } txt_state_e;

endpackage

// File: rtl/text_ram.sv
// Simple dual-port character buffer: one write port, one synchronous read port.
module text_ram
  import text_pkg::*;
#(
  parameter int DEPTH = 1200,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  char_t         wdata,
  input  logic [AW-1:0] raddr,
  output char_t         rdata
);

  char_t mem [DEPTH];

  // NOTE: the array has no reset so it maps onto block RAM; contents come from the clear sweep.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/text_overlay.sv
// Character-cell text layer: buffer write/clear control plus a 3-stage render pipe to the font ROM.
// Optional feature macro: TEXT_SCALE2_EN doubles every glyph pixel to 2x2 (16x16 cells).
module text_overlay
  import text_pkg::*;
#(
  parameter int COLS  = 40,
  parameter int ROWS  = 30,
  parameter int X_ORG = 0,
  parameter int Y_ORG = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] hcount,
  input  logic [9:0] vcount,
  input  logic       active_in,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [5:0] wr_col,
  input  logic [4:0] wr_row,
  input  logic [7:0] wr_char,
  output logic       wr_err,
  input  logic       clr_req,
  output logic       busy,
  output logic [7:0] char_addr,
  output logic [2:0] row_addr,
  input  logic [7:0] bitmap,
  output logic       pixel_on,
  output logic       active_out
);

  localparam int CELLS = COLS * ROWS;
  localparam int AW    = $clog2(CELLS);
`ifdef TEXT_SCALE2_EN
  localparam int SH_X = $clog2(CHAR_W) + 1;
  localparam int SH_Y = $clog2(CHAR_H) + 1;
`else
  localparam int SH_X = $clog2(CHAR_W);
  localparam int SH_Y = $clog2(CHAR_H);
`endif

  localparam logic [AW-1:0] LAST_CELL = AW'(CELLS - 1);
  localparam logic [6:0]    COLS_LIM  = 7'(COLS);
  localparam logic [5:0]    ROWS_LIM  = 6'(ROWS);

  // ---------------- control: clear sweep and write port ----------------
  txt_state_e    state;
  logic [AW-1:0] clr_ptr;
  logic          wr_fire;
  logic          wr_in_range;
  logic [AW-1:0] wr_cell;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  char_t         ram_wdata;

  assign busy        = (state == CLEAR);
  assign wr_ready    = (state == IDLE) && !clr_req;
  assign wr_fire     = wr_valid && wr_ready;
  assign wr_in_range = ({1'b0, wr_col} < COLS_LIM) && ({1'b0, wr_row} < ROWS_LIM);
  assign wr_cell     = AW'(wr_row) * AW'(COLS) + AW'(wr_col);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CLEAR;
      clr_ptr <= '0;
      wr_err  <= 1'b0;
    end else begin
      wr_err <= wr_fire && !wr_in_range;
      case (state)
        CLEAR: begin
          if (clr_ptr == LAST_CELL) begin
            state   <= IDLE;
            clr_ptr <= '0;
          end else begin
            clr_ptr <= clr_ptr + 1'b1;
          end
        end
        IDLE: begin
          if (clr_req) begin
            state   <= CLEAR;
            clr_ptr <= '0;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = wr_cell;
    ram_wdata = wr_char;
    if (state == CLEAR) begin
      ram_we    = 1'b1;
      ram_waddr = clr_ptr;
      ram_wdata = CHAR_SPACE;
    end else if (wr_fire && wr_in_range) begin
      ram_we = 1'b1;
    end
  end

  // ---------------- render pipeline ----------------
  logic [9:0]    h_s0, v_s0;
  logic          act_s0;
  logic [10:0]   dx_full, dy_full;
  logic [9:0]    dx, dy, cell_x, cell_y;
  logic          in_area_s0;
  logic [AW-1:0] rd_addr;
  char_t         rd_char;

  logic       in_s1, act_s1, in_s2, act_s2;
  logic [2:0] bs_s1, gr_s1, bs_s2;

  // Bit 10 of the widened difference is the borrow, i.e. the pixel lies left of / above the origin.
  assign dx_full    = {1'b0, h_s0} - 11'(X_ORG);
  assign dy_full    = {1'b0, v_s0} - 11'(Y_ORG);
  assign dx         = dx_full[9:0];
  assign dy         = dy_full[9:0];
  assign cell_x     = dx >> SH_X;
  assign cell_y     = dy >> SH_Y;
  assign in_area_s0 = act_s0 && !dx_full[10] && !dy_full[10] &&
                      (cell_x < 10'(COLS)) && (cell_y < 10'(ROWS));
  assign rd_addr    = in_area_s0 ? AW'(cell_y) * AW'(COLS) + AW'(cell_x) : '0;

  text_ram #(.DEPTH(CELLS), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (rd_addr),
    .rdata (rd_char)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_s0       <= '0;
      v_s0       <= '0;
      act_s0     <= 1'b0;
      in_s1      <= 1'b0;
      act_s1     <= 1'b0;
      bs_s1      <= '0;
      gr_s1      <= '0;
      in_s2      <= 1'b0;
      act_s2     <= 1'b0;
      bs_s2      <= '0;
      char_addr  <= CHAR_SPACE;
      row_addr   <= '0;
      pixel_on   <= 1'b0;
      active_out <= 1'b0;
    end else begin
      h_s0       <= hcount;
      v_s0       <= vcount;
      act_s0     <= active_in;
      in_s1      <= in_area_s0;
      act_s1     <= act_s0;
      bs_s1      <= dx[SH_X-1 -: 3];
      gr_s1      <= dy[SH_Y-1 -: 3];
      in_s2      <= in_s1;
      act_s2     <= act_s1;
      bs_s2      <= bs_s1;
      char_addr  <= rd_char;
      row_addr   <= gr_s1;
      pixel_on   <= in_s2 && bitmap[3'd7 - bs_s2];
      active_out <= act_s2;
    end
  end

endmodule

// File: tb/tb_text_overlay.sv
// Scoreboard bench for text_overlay: a default-origin instance and an X_ORG=100 instance share all inputs.
module tb_text_overlay;
  import text_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] hcount, vcount;
  logic       active_in;
  logic       wr_valid;
  logic [5:0] wr_col;
  logic [4:0] wr_row;
  logic [7:0] wr_char;
  logic       clr_req;

  logic       wr_ready, wr_err, busy, pixel_on, active_out;
  logic [7:0] char_addr, bitmap;
  logic [2:0] row_addr;

  logic       wr_ready_b, wr_err_b, busy_b, pixel_on_b, active_out_b;
  logic [7:0] char_addr_b, bitmap_b;
  logic [2:0] row_addr_b;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       chk;
    logic [7:0] ch;
    logic [2:0] row;
    logic       pix;
    logic       pix2;
    logic       act;
  } exp_t;

  exp_t char_q[$];
  exp_t pix_q[$];
  exp_t mon_e;
  logic       tok_in = 1'b0;
  logic [3:0] tok_sh = '0;

  always #5 clk = ~clk;

  text_overlay u_dut (
    .clk(clk), .rst_n(rst_n), .hcount(hcount), .vcount(vcount), .active_in(active_in),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_col(wr_col), .wr_row(wr_row),
    .wr_char(wr_char), .wr_err(wr_err), .clr_req(clr_req), .busy(busy),
    .char_addr(char_addr), .row_addr(row_addr), .bitmap(bitmap),
    .pixel_on(pixel_on), .active_out(active_out)
  );

  text_overlay #(.X_ORG(100)) u_dut_x (
    .clk(clk), .rst_n(rst_n), .hcount(hcount), .vcount(vcount), .active_in(active_in),
    .wr_valid(wr_valid), .wr_ready(wr_ready_b), .wr_col(wr_col), .wr_row(wr_row),
    .wr_char(wr_char), .wr_err(wr_err_b), .clr_req(clr_req), .busy(busy_b),
    .char_addr(char_addr_b), .row_addr(row_addr_b), .bitmap(bitmap_b),
    .pixel_on(pixel_on_b), .active_out(active_out_b)
  );

  // Small font ROM: '0', 'A', a solid block (0xDB); every other code is blank.
  function automatic logic [7:0] font(input logic [7:0] ch, input logic [2:0] row);
    logic [63:0] g;
    case (ch)
      8'h30:   g = 64'h78CC_DCFC_ECCC_7800;
      8'h41:   g = 64'h3078_CCCC_FCCC_CC00;
      8'hDB:   g = 64'hFFFF_FFFF_FFFF_FFFF;
      default: g = 64'h0;
    endcase
    return g[63 - 8*row -: 8];
  endfunction

  always_comb bitmap   = font(char_addr, row_addr);
  always_comb bitmap_b = font(char_addr_b, row_addr_b);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got no expected entry, required one at %0t", name, $time);
  endtask

  // Bench-side token pipe marks which DUT output cycles carry a scoreboard entry.
  always @(posedge clk) tok_sh <= {tok_sh[2:0], tok_in};

  always @(negedge clk) begin
    if (tok_sh[2]) begin
      if (char_q.size() == 0) fail_now("char_q_underflow");
      else begin
        mon_e = char_q.pop_front();
        if (mon_e.chk) begin
          check("char_addr", char_addr, mon_e.ch);
          check("row_addr", row_addr, mon_e.row);
        end
      end
    end
    if (tok_sh[3]) begin
      if (pix_q.size() == 0) fail_now("pix_q_underflow");
      else begin
        mon_e = pix_q.pop_front();
        check("pixel_on", pixel_on, mon_e.pix);
        check("active_out", active_out, mon_e.act);
        check("pixel_on_x100", pixel_on_b, mon_e.pix2);
        check("active_out_x100", active_out_b, mon_e.act);
      end
    end
  end

  // Drive one pixel (called at a negedge) and queue its expected response.
  task automatic pix(input int h, input int v, input logic act, input logic p, input logic p2,
                     input logic chk, input logic [7:0] ch, input logic [2:0] row);
    exp_t e;
    hcount    = 10'(h);
    vcount    = 10'(v);
    active_in = act;
    tok_in    = 1'b1;
    e = '{chk: chk, ch: ch, row: row, pix: p, pix2: p2, act: act};
    char_q.push_back(e);
    pix_q.push_back(e);
    @(negedge clk);
    tok_in = 1'b0;
  endtask

  task automatic flush();
    tok_in    = 1'b0;
    active_in = 1'b0;
    repeat (6) @(negedge clk);
    check("scoreboard_drained", pix_q.size() + char_q.size(), 0);
  endtask

  task automatic wr(input int col, input int row, input logic [7:0] ch, input logic exp_err);
    wr_col   = 6'(col);
    wr_row   = 5'(row);
    wr_char  = ch;
    wr_valid = 1'b1;
    #1 check("wr_ready", wr_ready, 1);
    @(negedge clk);
    wr_valid = 1'b0;
    check("wr_err", wr_err, exp_err);
    @(negedge clk);
    check("wr_err_one_cycle", wr_err, 0);
  endtask

  // Called at a negedge where a sweep with all cells outstanding is in progress.
  task automatic measure_clear(input string name);
    int   cnt = 0;
    logic rdy_seen = 1'b0;
    while (busy === 1'b1 && cnt < 3000) begin
      if (wr_ready !== 1'b0) rdy_seen = 1'b1;
      @(negedge clk);
      cnt++;
    end
    check({name, "_cycles"}, cnt, 1200);
    check({name, "_ready_low"}, rdy_seen, 0);
    check({name, "_ready_after"}, wr_ready, 1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_pixel_on"}, pixel_on, 0);
    check({tag, "_active_out"}, active_out, 0);
    check({tag, "_wr_err"}, wr_err, 0);
    check({tag, "_char_addr"}, char_addr, 8'h20);
    check({tag, "_row_addr"}, row_addr, 0);
    check({tag, "_busy"}, busy, 1);
    check({tag, "_wr_ready"}, wr_ready, 0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] g;
    logic [7:0] g1;
    int         vs[3];
    rst_n = 1'b0; hcount = '0; vcount = '0; active_in = 1'b0;
    wr_valid = 1'b0; wr_col = '0; wr_row = '0; wr_char = '0; clr_req = 1'b0;

    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    measure_clear("reset_sweep");

    // Blank buffer renders nothing; char_addr shows space on every in-area pixel.
    vs = '{0, 100, 239};
    foreach (vs[k])
      for (int h = 0; h < 320; h++) pix(h, vs[k], 1, 0, 0, 1, 8'h20, 3'(vs[k] % 8));
    flush();

    // Single glyph '0' at col 2 row 1: row 0 bitmap 01111000 on x 16..23, y 8.
    wr(2, 1, 8'h30, 0);
    g = 8'h78;
    for (int i = 0; i < 8; i++) pix(16 + i, 8, 1, g[7-i], 0, 1, 8'h30, 0);
    flush();

    // Out-of-range writes are dropped; col 40 row 0 would alias onto col 0 row 1.
    wr(40, 0, 8'h30, 1);
    wr(0, 30, 8'h30, 1);
    for (int i = 0; i < 8; i++) pix(i, 8, 1, 0, 0, 1, 8'h20, 0);
    flush();

    // Last cell: 'A' at x 312..319, y 232..239; just past the area stays dark.
    wr(39, 29, 8'h41, 0);
    g  = 8'h30;
    g1 = 8'h78;
    for (int i = 0; i < 8; i++) pix(312 + i, 232, 1, g[7-i], 0, 1, 8'h41, 0);
    for (int i = 0; i < 8; i++) pix(312 + i, 233, 1, g1[7-i], 0, 1, 8'h41, 1);
    pix(320, 232, 1, 0, 0, 0, 8'h00, 0);
    pix(319, 240, 1, 0, 0, 0, 8'h00, 0);
    flush();

    // Area bounds: solid block in cell 0; the X_ORG=100 instance shows it at x 100..107.
    wr(0, 0, 8'hDB, 0);
    pix(99, 0, 1, 0, 0, 0, 8'h00, 0);
    pix(100, 0, 1, 0, 1, 0, 8'h00, 0);
    pix(100, 0, 0, 0, 0, 0, 8'h00, 0);
    pix(0, 0, 1, 1, 0, 1, 8'hDB, 0);
    pix(0, 0, 0, 0, 0, 0, 8'h00, 0);
    pix(99, 3, 1, 0, 0, 0, 8'h00, 0);
    pix(107, 7, 1, 0, 1, 0, 8'h00, 0);
    pix(7, 5, 1, 1, 0, 1, 8'hDB, 5);
    flush();

    // Clear and an (out-of-range) write in the same IDLE cycle: clear wins, no wr_err.
    clr_req = 1'b1; wr_valid = 1'b1; wr_col = 6'd40; wr_row = 5'd0; wr_char = 8'h41;
    #1 check("wr_ready_during_clr_req", wr_ready, 0);
    check("busy_before_clr", busy, 0);
    @(negedge clk);
    clr_req = 1'b0; wr_valid = 1'b0;
    check("busy_after_clr", busy, 1);
    check("wr_err_clr_collision", wr_err, 0);
    measure_clear("clr_sweep");

    // Buffer is blank again after the sweep.
    pix(17, 8, 1, 0, 0, 1, 8'h20, 0);
    pix(0, 0, 1, 0, 0, 1, 8'h20, 0);
    pix(100, 0, 1, 0, 0, 1, 8'h20, 0);
    pix(313, 233, 1, 0, 0, 1, 8'h20, 1);
    flush();

    // Reset 500 cycles into a sweep, with an in-area pixel held on the inputs.
    hcount = 10'd0; vcount = 10'd3; active_in = 1'b1;
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    check("busy_mid_sweep_start", busy, 1);
    repeat (500) @(negedge clk);
    check("active_out_held", active_out, 1);
    check("row_addr_held", row_addr, 3);
    rst_n = 1'b0;
    #1 check_reset_vals("mid_reset");
    active_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    measure_clear("restart_sweep");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
